aes128_encrypt_core: RTL and testbench

//  AES-128 block encryptor per FIPS-197: 10 rounds, on-the-fly key expansion.

---
 rtl/aes128_encrypt_core.sv | 142 ++++++++++++++
 tb/tb_aes128_encrypt_core.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_core.sv
// AES-128 forward cipher built from ten round stages with on-the-fly key expansion.
// Each stage optionally registers its state and round key together, so data and key never skew.

module aes_round #(
   parameter logic [7:0] RCON  = 8'h01,
   parameter bit         FINAL = 1'b0,
   parameter bit         REG   = 1'b1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [127:0] st_in,
   input  logic [127:0] key_in,
   output logic [127:0] st_out,
   output logic [127:0] key_out
);

   localparam logic [2047:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Entry x sits at bit offset 8*(255-x), and 255-x is simply ~x.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   logic [31:0]  t, w0, w1, w2, w3;
   logic [127:0] key_nxt, sb_st, sr_st, st_nxt;

   // RotWord moves byte 12 to the end before SubWord.
   always_comb begin
      t  = {sbox(key_in[23:16]) ^ RCON, sbox(key_in[15:8]), sbox(key_in[7:0]), sbox(key_in[31:24])};
      w0 = key_in[127:96] ^ t;
      w1 = key_in[95:64] ^ w0;
      w2 = key_in[63:32] ^ w1;
      w3 = key_in[31:0] ^ w2;
      key_nxt = {w0, w1, w2, w3};
   end

   for (genvar n = 0; n < 16; n++) begin : g_sub
      assign sb_st[127-8*n -: 8] = sbox(st_in[127-8*n -: 8]);
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr_st[127-8*(r+4*c) -: 8] = sb_st[127-8*(r+4*((c+r)%4)) -: 8];
      end
   end

   if (FINAL) begin : g_final
      assign st_nxt = sr_st ^ key_nxt;
   end else begin : g_mix
      logic [127:0] mc_st;
      for (genvar c = 0; c < 4; c++) begin : g_mc
         assign mc_st[127-32*c -: 32] = mix_col(sr_st[127-32*c -: 32]);
      end
      assign st_nxt = mc_st ^ key_nxt;
   end

   if (REG) begin : g_reg
      always_ff @(posedge clk) begin
         if (clr) begin
            st_out  <= '0;
            key_out <= '0;
         end else begin
            st_out  <= st_nxt;
            key_out <= key_nxt;
         end
      end
   end else begin : g_comb
      assign st_out  = st_nxt;
      assign key_out = key_nxt;
   end

endmodule

module aes128_encrypt_core #(
   parameter int LATENCY = 10
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [127:0] dat_in,
   input  logic [127:0] key,
   output logic [127:0] dat_out,
   output logic [127:0] inv_key
);

   localparam logic [79:0] RCONS = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   logic [10:0][127:0] st, rk;

   assign st[0] = dat_in ^ key;
   assign rk[0] = key;

   // Stage i is registered when i <= LATENCY, so the first LATENCY rounds carry the flops.
   for (genvar i = 1; i <= 10; i++) begin : g_round
      aes_round #(
         .RCON  (RCONS[80-8*i +: 8]),
         .FINAL (i == 10),
         .REG   (i <= LATENCY)
      ) u_round (
         .clk     (clk),
         .clr     (clr),
         .st_in   (st[i-1]),
         .key_in  (rk[i-1]),
         .st_out  (st[i]),
         .key_out (rk[i])
      );
   end

   assign dat_out = st[10];
   assign inv_key = rk[10];

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed bench for aes128_encrypt_core: known-answer vectors, a behavioural AES model,
// back-to-back streaming at LATENCY=10, and clear behaviour.

module tb_aes128_encrypt_core;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic [127:0] dat_in = '0, key = '0;
   logic [127:0] d0_out, k0_out, d10_out, k10_out;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]   sb [256];
   logic [127:0] e_ct [64];
   logic [127:0] e_k  [64];

   localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;

   always #5 clk = ~clk;

   aes128_encrypt_core #(.LATENCY(0)) u0 (
      .clk(clk), .clr(clr), .dat_in(dat_in), .key(key), .dat_out(d0_out), .inv_key(k0_out));

   aes128_encrypt_core #(.LATENCY(10)) u10 (
      .clk(clk), .clr(clr), .dat_in(dat_in), .key(key), .dat_out(d10_out), .inv_key(k10_out));

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = xt(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int s);
      return (b << s) | (b >> (8 - s));
   endfunction

   // S-box derived from the field inverse plus the affine map, independent of any table.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic aes_ref(input logic [127:0] pt, input logic [127:0] k,
                          output logic [127:0] ct, output logic [127:0] kout);
      logic [7:0] s [16];
      logic [7:0] w [16];
      logic [7:0] tmp [16];
      logic [7:0] rc = 8'h01;
      logic [7:0] t0, t1, t2, t3;
      for (int i = 0; i < 16; i++) begin
         w[i] = k[127-8*i -: 8];
         s[i] = pt[127-8*i -: 8] ^ w[i];
      end
      for (int r = 1; r <= 10; r++) begin
         t0 = sb[w[13]] ^ rc; t1 = sb[w[14]]; t2 = sb[w[15]]; t3 = sb[w[12]];
         w[0] ^= t0; w[1] ^= t1; w[2] ^= t2; w[3] ^= t3;
         for (int i = 4; i < 16; i++) w[i] ^= w[i-4];
         rc = xt(rc);
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) tmp[q+4*c] = s[q+4*((c+q)%4)];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(tmp[4*c],2) ^ gmul(tmp[4*c+1],3) ^ tmp[4*c+2] ^ tmp[4*c+3];
               s[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1],2) ^ gmul(tmp[4*c+2],3) ^ tmp[4*c+3];
               s[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gmul(tmp[4*c+2],2) ^ gmul(tmp[4*c+3],3);
               s[4*c+3] = gmul(tmp[4*c],3) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gmul(tmp[4*c+3],2);
            end else begin
               for (int q = 0; q < 4; q++) s[4*c+q] = tmp[4*c+q];
            end
         end
         for (int i = 0; i < 16; i++) s[i] ^= w[i];
      end
      for (int i = 0; i < 16; i++) begin
         ct[127-8*i -: 8]   = s[i];
         kout[127-8*i -: 8] = w[i];
      end
   endtask

   initial begin
      logic [127:0] rct, rkey, rp, rk;
      build_sbox();

      // Known-answer vectors on the combinational build
      dat_in = PT1; key = K1; #1;
      chk("kat1_dat", d0_out, 128'h3925841d02dc09fbdc118597196a0b32);
      chk("kat1_key", k0_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("rnd1_st",  u0.st[1], 128'ha49c7ff2689f352b6b5bea43026a5049);
      chk("rnd1_key", u0.rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      dat_in = PT2; key = K2; #1;
      chk("kat2_dat", d0_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("kat2_key", k0_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      for (int i = 0; i < 4; i++) begin
         rp = {$urandom, $urandom, $urandom, $urandom};
         rk = {$urandom, $urandom, $urandom, $urandom};
         dat_in = rp; key = rk; #1;
         aes_ref(rp, rk, rct, rkey);
         chk("rand_dat", d0_out, rct);
         chk("rand_key", k0_out, rkey);
      end

      // Clear, then ten back-to-back blocks
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      chk("clr_dat", d10_out, '0);
      chk("clr_key", k10_out, '0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c >= 10) begin
            chk("strm_dat", d10_out, e_ct[c-10]);
            chk("strm_key", k10_out, e_k[c-10]);
         end
         if (c < 10) begin
            dat_in = PT1 + 128'(c); key = K1 + 128'(c);
            aes_ref(dat_in, key, e_ct[c], e_k[c]);
         end
      end

      // Mid-stream clear while the pipe is full, then a fresh stream
      for (int c = 0; c < 35; c++) begin
         @(negedge clk);
         if (c >= 10 && c < 15) begin
            chk("pre_dat", d10_out, e_ct[c-10]);
            chk("pre_key", k10_out, e_k[c-10]);
         end
         if (c == 15) begin
            chk("mclr_dat", d10_out, '0);
            chk("mclr_key", k10_out, '0);
         end
         if (c >= 25) begin
            chk("post_dat", d10_out, e_ct[c-25+20]);
            chk("post_key", k10_out, e_k[c-25+20]);
         end
         if (c < 14) begin
            dat_in = K2 ^ (128'(c) << 64); key = PT2 + 128'(c);
            aes_ref(dat_in, key, e_ct[c], e_k[c]);
         end else if (c == 14) begin
            clr = 1'b1;
            dat_in = '1; key = '1;
         end else begin
            clr = 1'b0;
            if (c < 25) begin
               dat_in = PT2 + 128'(c - 15); key = K2 + 128'(c - 15);
               aes_ref(dat_in, key, e_ct[c-15+20], e_k[c-15+20]);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
